// File: rtl/gesture_command_encoder.sv
// Gesture-to-command encoder.
// Takes two-hand coordinate frames, compares them against a calibrated
// neutral pose, and emits an 8-bit drone command once the same candidate
// has been seen for STABLE_FRAMES consecutive frames and differs from the
// last command the consumer accepted.
module gesture_command_encoder #(
  parameter logic [15:0] DEADBAND      = 16'd200,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  input  logic [15:0] z1,
  input  logic [15:0] x2,
  input  logic [15:0] y2,
  input  logic [15:0] z2,
  input  logic        recal,
  input  logic        cmd_ack,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        calibrated,
  output logic [7:0]  dropped,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    CALIB = 3'd0,
    IDLE  = 3'd1,
    EVAL  = 3'd2,
    SEND  = 3'd3
  } state_t;

  localparam logic [3:0] SF = STABLE_FRAMES[3:0];

  state_t      r_state, w_state_nxt;
  logic [15:0] r_nx1, r_ny1, r_nz1, r_nx2, r_ny2, r_nz2;
  logic [15:0] r_fx1, r_fy1, r_fz1, r_fx2, r_fy2, r_fz2;
  logic [3:0]  r_cnt;
  logic [7:0]  r_prev;
  logic [7:0]  r_last;
  logic [7:0]  r_cmd;
  logic [7:0]  r_dropped;

  logic [7:0]  w_cand;
  logic [3:0]  w_cnt_nxt;
  logic        w_go;
  logic        w_unused;

  // z1 and y2 are captured for completeness but carry no command meaning.
  assign w_unused = ^{r_nz1, r_ny2, r_fz1, r_fy2};

  // Per-axis deadband classifier: 01 above, 10 below, 00 inside (edges inclusive).
  function automatic logic [1:0] axis_code(input logic [15:0] cur, input logic [15:0] n);
    logic signed [16:0] d;
    logic signed [16:0] db;
    d  = $signed({1'b0, cur}) - $signed({1'b0, n});
    db = $signed({1'b0, DEADBAND});
    if (d > db)       axis_code = 2'b01;
    else if (d < -db) axis_code = 2'b10;
    else              axis_code = 2'b00;
  endfunction

  assign w_cand = {axis_code(r_fx2, r_nx2), axis_code(r_fz2, r_nz2),
                   axis_code(r_fy1, r_ny1), axis_code(r_fx1, r_nx1)};

  // Stability counter update and send decision, only meaningful in EVAL.
  always_comb begin
    w_cnt_nxt = 4'd1;
    if (w_cand == r_prev) w_cnt_nxt = (r_cnt >= SF) ? SF : r_cnt + 4'd1;
    w_go = (w_cnt_nxt == SF) && (w_cand != r_last);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= CALIB;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; recal overrides every other input.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CALIB:   if (ready)   w_state_nxt = IDLE;
      IDLE:    if (ready)   w_state_nxt = EVAL;
      EVAL:    w_state_nxt = w_go ? SEND : IDLE;
      SEND:    if (cmd_ack) w_state_nxt = IDLE;
      default: w_state_nxt = CALIB;
    endcase
    if (recal) w_state_nxt = CALIB;
  end

  // Outputs decoded from the state and the command register.
  always_comb begin
    cmd_valid  = (r_state == SEND);
    calibrated = (r_state != CALIB);
    state      = r_state;
    cmd        = r_cmd;
    dropped    = r_dropped;
  end

  // Neutral/frame capture, stability tracking and command hand-off.
  always_ff @(posedge clock) begin
    if (reset) begin
      {r_nx1, r_ny1, r_nz1, r_nx2, r_ny2, r_nz2} <= '0;
      {r_fx1, r_fy1, r_fz1, r_fx2, r_fy2, r_fz2} <= '0;
      r_cnt  <= '0;
      r_prev <= '0;
      r_last <= '0;
      r_cmd  <= '0;
    end else if (recal) begin
      r_cnt  <= '0;
      r_prev <= '0;
      r_last <= '0;
    end else begin
      case (r_state)
        CALIB: if (ready) {r_nx1, r_ny1, r_nz1, r_nx2, r_ny2, r_nz2} <= {x1, y1, z1, x2, y2, z2};
        IDLE:  if (ready) {r_fx1, r_fy1, r_fz1, r_fx2, r_fy2, r_fz2} <= {x1, y1, z1, x2, y2, z2};
        EVAL: begin
          r_cnt  <= w_cnt_nxt;
          r_prev <= w_cand;
          if (w_go) r_cmd <= w_cand;
        end
        SEND:  if (cmd_ack) r_last <= r_cmd;
        default: ;
      endcase
    end
  end

  // Saturating count of frames that arrive while a frame is being evaluated or sent.
  always_ff @(posedge clock) begin
    if (reset)
      r_dropped <= '0;
    else if (!recal && ready && (r_state == EVAL || r_state == SEND) && r_dropped != 8'hFF)
      r_dropped <= r_dropped + 8'd1;
  end

endmodule

// File: tb/tb_gesture_command_encoder.sv
// Directed bench for gesture_command_encoder: expected commands are queued
// with their due cycle when a frame is driven, and matched when cmd_valid rises.
module tb_gesture_command_encoder;

  logic        clock = 1'b0;
  logic        reset, ready, recal, cmd_ack;
  logic [15:0] x1, y1, z1, x2, y2, z2;
  logic        cmd_valid, calibrated;
  logic [7:0]  cmd, dropped;
  logic [2:0]  state;

  gesture_command_encoder dut (
    .clock(clock), .reset(reset), .ready(ready),
    .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
    .recal(recal), .cmd_ack(cmd_ack),
    .cmd_valid(cmd_valid), .cmd(cmd), .calibrated(calibrated),
    .dropped(dropped), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] cmd;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       e_m;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic       pv    = 1'b0;
  logic [7:0] held  = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard side: every rising cmd_valid must match the queue head,
  // including its due cycle; a held command must not change.
  always @(negedge clock) begin
    if (cmd_valid === 1'b1 && !pv) begin
      n_vec++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_cmd_valid observed cmd=%0h cycle=%0d required none", cmd, cyc);
      end
      if (q.size() != 0) begin
        e_m = q.pop_front();
        n_vec += 2;
        assert (cmd === e_m.cmd) else begin
          n_err++;
          $error("FAIL cmd_value observed=%0h required=%0h", cmd, e_m.cmd);
        end
        assert (cyc === e_m.cyc) else begin
          n_err++;
          $error("FAIL cmd_latency observed cycle=%0d required cycle=%0d", cyc, e_m.cyc);
        end
      end
      held = cmd;
    end else if (cmd_valid === 1'b1 && pv) begin
      n_vec++;
      assert (cmd === held) else begin
        n_err++;
        $error("FAIL cmd_stable observed=%0h required=%0h", cmd, held);
      end
    end
    pv = (cmd_valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // One ready pulse; if a command is expected it must be valid two cycles later.
  task automatic frame(input logic [15:0] ax1, input logic [15:0] ay1, input logic [15:0] az2,
                       input logic [15:0] ax2, input bit exp_send, input logic [7:0] exp_cmd);
    exp_t t;
    @(posedge clock); #1;
    x1 = ax1; y1 = ay1; z2 = az2; x2 = ax2;
    z1 = 16'($urandom); y2 = 16'($urandom);
    ready = 1'b1;
    if (exp_send) begin
      t.cmd = exp_cmd;
      t.cyc = cyc + 2;
      q.push_back(t);
    end
    @(posedge clock); #1;
    ready = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic ack();
    @(posedge clock); #1 cmd_ack = 1'b1;
    @(posedge clock); #1 cmd_ack = 1'b0;
    @(negedge clock);
    chk("ack_state", 16'(state), 16'd1);
    chk("ack_valid", 16'(cmd_valid), 16'd0);
  endtask

  task automatic pulse_recal();
    @(posedge clock); #1 recal = 1'b1;
    @(posedge clock); #1 recal = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; recal = 1'b0; cmd_ack = 1'b0;
    x1 = '0; y1 = '0; z1 = '0; x2 = '0; y2 = '0; z2 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_valid", 16'(cmd_valid), 16'd0);
    chk("rst_cmd", 16'(cmd), 16'd0);
    chk("rst_calib", 16'(calibrated), 16'd0);
    chk("rst_dropped", 16'(dropped), 16'd0);

    // Calibrate at 1000, then stable roll right.
    frame(1000, 1000, 1000, 1000, 0, 8'h00);
    @(negedge clock);
    chk("calib_set", 16'(calibrated), 16'd1);
    chk("calib_state", 16'(state), 16'd1);
    frame(1300, 1000, 1000, 1000, 0, 8'h00);
    frame(1300, 1000, 1000, 1000, 0, 8'h00);
    frame(1300, 1000, 1000, 1000, 1, 8'h01);
    @(negedge clock);
    chk("roll_state", 16'(state), 16'd3);
    ack();

    // No repeat of an accepted command, then return to neutral.
    repeat (5) frame(1300, 1000, 1000, 1000, 0, 8'h00);
    frame(1000, 1000, 1000, 1000, 0, 8'h00);
    frame(1000, 1000, 1000, 1000, 0, 8'h00);
    frame(1000, 1000, 1000, 1000, 1, 8'h00);
    ack();

    // Deadband edges: +/-200 are neutral, -201 is pitch down.
    repeat (3) frame(1000, 1200, 1000, 1000, 0, 8'h00);
    repeat (3) frame(1000, 800, 1000, 1000, 0, 8'h00);
    frame(1000, 799, 1000, 1000, 0, 8'h00);
    frame(1000, 799, 1000, 1000, 0, 8'h00);
    frame(1000, 799, 1000, 1000, 1, 8'h08);
    ack();

    // Backpressure: four frames dropped while pending, fifth coincides with ack.
    frame(700, 1000, 1000, 1000, 0, 8'h00);
    frame(700, 1000, 1000, 1000, 0, 8'h00);
    frame(700, 1000, 1000, 1000, 1, 8'h02);
    repeat (4) frame(1300, 1300, 1300, 1300, 0, 8'h00);
    @(negedge clock);
    chk("bp_dropped", 16'(dropped), 16'd4);
    chk("bp_cmd", 16'(cmd), 16'h02);
    @(posedge clock); #1 ready = 1'b1; cmd_ack = 1'b1;
    @(posedge clock); #1 ready = 1'b0; cmd_ack = 1'b0;
    @(negedge clock);
    chk("bp_ack_dropped", 16'(dropped), 16'd5);
    chk("bp_ack_state", 16'(state), 16'd1);

    // Recal abandons a pending throttle command.
    frame(1000, 1000, 1300, 1000, 0, 8'h00);
    frame(1000, 1000, 1300, 1000, 0, 8'h00);
    frame(1000, 1000, 1300, 1000, 1, 8'h10);
    pulse_recal();
    chk("recal_valid", 16'(cmd_valid), 16'd0);
    chk("recal_calib", 16'(calibrated), 16'd0);
    chk("recal_state", 16'(state), 16'd0);
    chk("recal_dropped", 16'(dropped), 16'd5);
    // Recal together with ready discards that frame.
    @(posedge clock); #1 recal = 1'b1; ready = 1'b1; x1 = 16'd2000;
    @(posedge clock); #1 recal = 1'b0; ready = 1'b0;
    @(negedge clock);
    chk("recal_ready_state", 16'(state), 16'd0);
    frame(1000, 1000, 1000, 1000, 0, 8'h00);
    @(negedge clock);
    chk("recal_recalib", 16'(calibrated), 16'd1);

    // Yaw packing in both directions.
    frame(1000, 1000, 1000, 1300, 0, 8'h00);
    frame(1000, 1000, 1000, 1300, 0, 8'h00);
    frame(1000, 1000, 1000, 1300, 1, 8'h40);
    ack();
    frame(1000, 1000, 1000, 700, 0, 8'h00);
    frame(1000, 1000, 1000, 700, 0, 8'h00);
    frame(1000, 1000, 1000, 700, 1, 8'h80);
    ack();

    // Flicker never stabilises.
    for (int i = 0; i < 10; i++)
      frame((i % 2 == 0) ? 16'd1300 : 16'd1000, 1000, 1000, 1000, 0, 8'h00);

    // A ready arriving during EVAL is dropped.
    @(posedge clock); #1 x1 = 16'd1000; ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1 ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("eval_drop", 16'(dropped), 16'd6);
    chk("eval_drop_valid", 16'(cmd_valid), 16'd0);

    // Dropped counter saturates.
    frame(1300, 1000, 1000, 1000, 0, 8'h00);
    frame(1300, 1000, 1000, 1000, 0, 8'h00);
    frame(1300, 1000, 1000, 1000, 1, 8'h01);
    @(posedge clock); #1 ready = 1'b1;
    repeat (260) @(posedge clock);
    #1 ready = 1'b0;
    @(negedge clock);
    chk("drop_sat", 16'(dropped), 16'd255);
    chk("drop_sat_state", 16'(state), 16'd3);

    // Reset mid-SEND overrides recal, ready and ack.
    @(posedge clock); #1 reset = 1'b1; recal = 1'b1; cmd_ack = 1'b1; ready = 1'b1;
    @(posedge clock); #1 reset = 1'b0; recal = 1'b0; cmd_ack = 1'b0; ready = 1'b0;
    @(negedge clock);
    chk("rst2_state", 16'(state), 16'd0);
    chk("rst2_valid", 16'(cmd_valid), 16'd0);
    chk("rst2_cmd", 16'(cmd), 16'd0);
    chk("rst2_calib", 16'(calibrated), 16'd0);
    chk("rst2_dropped", 16'(dropped), 16'd0);
    repeat (3) @(posedge clock);
    chk("queue_empty", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
